// File: rtl/ad7946_ctrl.sv
// Sequencer for one AD7946-style serial ADC: power-down, convert start, channel select,
// SCLK generation, frame capture and a one-entry valid/ready result register.
module ad7946_ctrl #(
  parameter int unsigned CLK_DIV = 2,  // clk cycles per SCLK half-period, >= 1
  parameter int unsigned T_PWRUP = 16,
  parameter int unsigned T_CSSU  = 2,
  parameter int unsigned T_QUIET = 4   // >= 2 so chsel can settle a cycle before cs_n falls
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [1:0]  chan_mode,
  output logic        pden,
  output logic        chsel,
  output logic        cs_n,
  output logic        sclk,
  input  logic        sdo,
  output logic [11:0] m_data,
  output logic        m_chan,
  output logic        m_valid,
  input  logic        m_ready,
  input  logic        clr_status,
  output logic        overrun,
  output logic        fmt_err
);

  localparam logic [2:0] StOff   = 3'd0;
  localparam logic [2:0] StPwrup = 3'd1;
  localparam logic [2:0] StQuiet = 3'd2;
  localparam logic [2:0] StCssu  = 3'd3;
  localparam logic [2:0] StShift = 3'd4;
  localparam logic [2:0] StDone  = 3'd5;

  localparam logic [15:0] PwrupLast = 16'(T_PWRUP - 1);
  localparam logic [15:0] QuietLast = 16'(T_QUIET - 1);
  localparam logic [15:0] QuietSel  = 16'(T_QUIET - 2);
  localparam logic [15:0] CssuLast  = 16'(T_CSSU - 1);
  localparam logic [15:0] DivLast   = 16'(CLK_DIV - 1);

  logic [2:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [4:0]  half_q, half_d;
  logic [15:0] shreg_q, shreg_d;
  logic        pden_q, pden_d;
  logic        cs_n_q, cs_n_d;
  logic        sclk_q, sclk_d;
  logic        chsel_q, chsel_d;
  logic        alt_q, alt_d;
  logic [11:0] m_data_q, m_data_d;
  logic        m_chan_q, m_chan_d;
  logic        m_valid_q, m_valid_d;
  logic        overrun_q, overrun_d;
  logic        fmt_err_q, fmt_err_d;
  logic        done;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    half_d  = half_q;
    shreg_d = shreg_q;
    pden_d  = pden_q;
    cs_n_d  = cs_n_q;
    sclk_d  = sclk_q;
    chsel_d = chsel_q;
    alt_d   = alt_q;
    case (state_q)
      StOff: begin
        cnt_d = 16'd0;
        if (enable) begin
          state_d = StPwrup;
          pden_d  = 1'b0;
          alt_d   = 1'b0;
        end
      end
      StPwrup: begin
        if (cnt_q == PwrupLast) begin
          state_d = StQuiet;
          cnt_d   = 16'd0;
        end
      end
      StQuiet: begin
        // Channel is chosen one cycle ahead so it is stable when cs_n falls.
        if (cnt_q == QuietSel) begin
          chsel_d = chan_mode[1] ? alt_q : chan_mode[0];
          if (chan_mode[1]) alt_d = ~alt_q;
        end
        if (cnt_q == QuietLast) begin
          cnt_d = 16'd0;
          if (!enable) begin
            state_d = StOff;
            pden_d  = 1'b1;
          end else begin
            state_d = StCssu;
            cs_n_d  = 1'b0;
          end
        end
      end
      StCssu: begin
        if (cnt_q == CssuLast) begin
          state_d = StShift;
          cnt_d   = 16'd0;
          half_d  = 5'd0;
          sclk_d  = 1'b0;
        end
      end
      StShift: begin
        if (cnt_q == DivLast) begin
          cnt_d  = 16'd0;
          half_d = half_q + 5'd1;
          sclk_d = ~sclk_q;
          if (!sclk_q) shreg_d = {shreg_q[14:0], sdo};
          if (half_q == 5'd31) begin
            state_d = StDone;
            cs_n_d  = 1'b1;
            sclk_d  = 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StQuiet;
        cnt_d   = 16'd0;
      end
      default: begin
        state_d = StOff;
        cnt_d   = 16'd0;
        pden_d  = 1'b1;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b1;
      end
    endcase
  end

  assign done = (state_q == StDone);

  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_chan_d  = m_chan_q;
    if (done) begin
      m_valid_d = 1'b1;
      m_data_d  = shreg_q[13:2];
      m_chan_d  = shreg_q[14];
    end else if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end
    // A set in the same cycle as clr_status wins.
    overrun_d = (done && m_valid_q && !m_ready) || (overrun_q && !clr_status);
    fmt_err_d = (done && (shreg_q[15] || (shreg_q[1:0] != 2'b00))) ||
                (fmt_err_q && !clr_status);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StOff;
      cnt_q     <= 16'd0;
      half_q    <= 5'd0;
      shreg_q   <= 16'd0;
      pden_q    <= 1'b1;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b1;
      chsel_q   <= 1'b0;
      alt_q     <= 1'b0;
      m_data_q  <= 12'd0;
      m_chan_q  <= 1'b0;
      m_valid_q <= 1'b0;
      overrun_q <= 1'b0;
      fmt_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      half_q    <= half_d;
      shreg_q   <= shreg_d;
      pden_q    <= pden_d;
      cs_n_q    <= cs_n_d;
      sclk_q    <= sclk_d;
      chsel_q   <= chsel_d;
      alt_q     <= alt_d;
      m_data_q  <= m_data_d;
      m_chan_q  <= m_chan_d;
      m_valid_q <= m_valid_d;
      overrun_q <= overrun_d;
      fmt_err_q <= fmt_err_d;
    end
  end

  assign pden    = pden_q;
  assign cs_n    = cs_n_q;
  assign sclk    = sclk_q;
  assign chsel   = chsel_q;
  assign m_data  = m_data_q;
  assign m_chan  = m_chan_q;
  assign m_valid = m_valid_q;
  assign overrun = overrun_q;
  assign fmt_err = fmt_err_q;

endmodule

// File: tb/tb_ad7946_ctrl.sv
// Bench for ad7946_ctrl: ADC frame model feeding a scoreboard of expected results,
// plus per-feature timing and flag checks.
module tb_ad7946_ctrl;

  localparam int FirstCs = 16 + 4 + 1;  // T_PWRUP + T_QUIET + 1
  localparam int Period  = 2 + 64 + 4 + 1;

  typedef struct packed {
    logic        chan;
    logic [11:0] data;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  chan_mode = 2'b00;
  logic        pden, chsel, cs_n, sclk;
  logic        sdo = 1'b0;
  logic [11:0] m_data;
  logic        m_chan, m_valid, overrun, fmt_err;
  logic        m_ready = 1'b1;
  logic        clr_status = 1'b0;

  int n_total = 0;
  int n_pass = 0;
  int cyc = 0;

  // ADC model and scoreboard state
  logic        inject_bad = 1'b0;
  logic        in_frame = 1'b0;
  logic [15:0] adc_frame = 16'd0;
  logic [11:0] conv_cnt [2] = '{12'd0, 12'd0};
  int          fall_cnt = 0;
  int          cs_falls = 0;
  res_t        sb [$];
  res_t        obs_q [$];
  int          n_writes = 0;
  int          valid_bad = 0;
  int          sclk_viol = 0;
  logic        wr_pending = 1'b0;
  logic        cs_prev = 1'b1;

  res_t plan [5] = '{'{1'b0, 12'h000}, '{1'b1, 12'h000}, '{1'b0, 12'h001},
                     '{1'b1, 12'h001}, '{1'b0, 12'h002}};
  logic plan_chsel [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  ad7946_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .chan_mode (chan_mode),
    .pden      (pden),
    .chsel     (chsel),
    .cs_n      (cs_n),
    .sclk      (sclk),
    .sdo       (sdo),
    .m_data    (m_data),
    .m_chan    (m_chan),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .clr_status(clr_status),
    .overrun   (overrun),
    .fmt_err   (fmt_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Frame = {0, chsel at convert start, per-channel count, 0, inject_bad}, MSB first.
  always @(negedge cs_n or posedge cs_n or negedge sclk) begin
    if (cs_n) begin
      if (in_frame && fall_cnt != 16 && sb.size() > 0) sb.pop_back();
      in_frame <= 1'b0;
    end else if (!in_frame) begin
      in_frame  <= 1'b1;
      adc_frame <= {1'b0, chsel, conv_cnt[chsel], 1'b0, inject_bad};
      sb.push_back(res_t'{chsel, conv_cnt[chsel]});
      conv_cnt[chsel] <= conv_cnt[chsel] + 12'd1;
      fall_cnt  <= 0;
      cs_falls  <= cs_falls + 1;
      sdo       <= 1'b0;
    end else if (!sclk && fall_cnt < 16) begin
      sdo      <= adc_frame[15 - fall_cnt];
      fall_cnt <= fall_cnt + 1;
    end
  end

  // Result register is written one cycle after cs_n rises on a complete frame.
  always @(negedge clk) begin
    if (!rst_n) begin
      wr_pending <= 1'b0;
      cs_prev    <= 1'b1;
    end else begin
      if (wr_pending) begin
        obs_q.push_back(res_t'{m_chan, m_data});
        if (!m_valid) valid_bad <= valid_bad + 1;
        n_writes <= n_writes + 1;
      end
      wr_pending <= cs_n && !cs_prev && (fall_cnt == 16);
      if (cs_n && !sclk) sclk_viol <= sclk_viol + 1;
      cs_prev <= cs_n;
    end
  end

  task automatic wait_cs(input logic val, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (cs_n === val) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_pden(input logic val, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (pden === val) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_writes(input int target, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (n_writes >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int bad = 0;
    int falls0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_total++;
    if ({pden, cs_n, sclk, chsel, m_valid, m_chan, overrun, fmt_err, m_data} !==
        {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000})
      $display("FAIL reset_values: got pden=%b cs_n=%b sclk=%b chsel=%b v=%b ch=%b ov=%b fe=%b d=%h",
               pden, cs_n, sclk, chsel, m_valid, m_chan, overrun, fmt_err, m_data);
    else n_pass++;
    @(posedge clk);
    #1 rst_n = 1'b1;
    falls0 = cs_falls;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if ({pden, cs_n, sclk, m_valid} !== 4'b1110) bad++;
    end
    n_total++;
    if (bad != 0) $display("FAIL idle_outputs: got %0d bad cycles exp 0", bad);
    else n_pass++;
    n_total++;
    if (cs_falls != falls0) $display("FAIL idle_no_cs: got %0d cs_n falls exp 0", cs_falls - falls0);
    else n_pass++;
  endtask

  task automatic test_alternate();
    int t0, last;
    bit ok;
    res_t o;
    chan_mode = 2'b10;
    m_ready   = 1'b1;
    @(posedge clk);
    #1 enable = 1'b1;
    t0 = cyc;
    wait_pden(1'b0, 10, ok);
    n_total++;
    if (!ok || cyc - t0 != 1) $display("FAIL pden_fall: got %0d cycles ok=%0d exp 1", cyc - t0, ok);
    else n_pass++;
    last = 0;
    for (int f = 0; f < 5; f++) begin
      wait_cs(1'b0, 200, ok);
      n_total++;
      if (!ok) $display("FAIL cs_fall_timeout: frame %0d got none exp cs_n fall", f);
      else n_pass++;
      n_total++;
      if (f == 0 && cyc - t0 != FirstCs)
        $display("FAIL first_cs_time: got %0d exp %0d", cyc - t0, FirstCs);
      else if (f != 0 && cyc - last != Period)
        $display("FAIL frame_period: frame %0d got %0d exp %0d", f, cyc - last, Period);
      else n_pass++;
      last = cyc;
      n_total++;
      if (chsel !== plan_chsel[f])
        $display("FAIL chsel_alt: frame %0d got %b exp %b", f, chsel, plan_chsel[f]);
      else n_pass++;
      if (f == 4) enable = 1'b0;
      wait_cs(1'b1, 200, ok);
      n_total++;
      if (!ok || fall_cnt != 16)
        $display("FAIL sclk_falls: frame %0d got %0d exp 16", f, fall_cnt);
      else n_pass++;
    end
    wait_pden(1'b1, 50, ok);
    n_total++;
    if (obs_q.size() != 5) $display("FAIL alt_result_count: got %0d exp 5", obs_q.size());
    else n_pass++;
    for (int i = 0; i < 5 && obs_q.size() > 0; i++) begin
      o = obs_q.pop_front();
      n_total++;
      if (o !== plan[i])
        $display("FAIL alt_result: idx %0d got (%b,%h) exp (%b,%h)", i, o.chan, o.data,
                 plan[i].chan, plan[i].data);
      else n_pass++;
    end
    n_total++;
    if ({fmt_err, overrun} !== 2'b00) $display("FAIL alt_flags: got fe=%b ov=%b exp 0 0", fmt_err, overrun);
    else n_pass++;
    n_total++;
    if (sclk_viol != 0 || valid_bad != 0)
      $display("FAIL sclk_idle_valid: got sclk_viol=%0d valid_bad=%0d exp 0 0", sclk_viol, valid_bad);
    else n_pass++;
    sb.delete();
    obs_q.delete();
  endtask

  task automatic test_backpressure();
    bit ok;
    int base;
    res_t e, o;
    chan_mode = 2'b00;
    m_ready   = 1'b0;
    base      = n_writes;
    @(posedge clk);
    #1 enable = 1'b1;
    wait_writes(base + 1, 300, ok);
    n_total++;
    if (!ok || overrun !== 1'b0 || m_valid !== 1'b1)
      $display("FAIL bp_first: got ok=%0d ov=%b v=%b exp 1 0 1", ok, overrun, m_valid);
    else n_pass++;
    wait_writes(base + 2, 300, ok);
    n_total++;
    if (!ok || overrun !== 1'b1) $display("FAIL bp_overrun: got ok=%0d ov=%b exp 1 1", ok, overrun);
    else n_pass++;
    for (int i = 0; i < 2 && obs_q.size() > 0 && sb.size() > 0; i++) begin
      e = sb.pop_front();
      o = obs_q.pop_front();
      n_total++;
      if (o !== e) $display("FAIL bp_sb: idx %0d got (%b,%h) exp (%b,%h)", i, o.chan, o.data, e.chan, e.data);
      else n_pass++;
    end
    n_total++;
    if ({m_chan, m_data} !== {e.chan, e.data})
      $display("FAIL bp_hold_second: got (%b,%h) exp (%b,%h)", m_chan, m_data, e.chan, e.data);
    else n_pass++;
    @(posedge clk);
    #1 clr_status = 1'b1;
    @(posedge clk);
    #1 clr_status = 1'b0;
    @(negedge clk);
    n_total++;
    if (overrun !== 1'b0 || m_valid !== 1'b1)
      $display("FAIL bp_clear: got ov=%b v=%b exp 0 1", overrun, m_valid);
    else n_pass++;
    wait_cs(1'b0, 200, ok);
    n_total++;
    if (chsel !== 1'b0) $display("FAIL bp_chsel: got %b exp 0", chsel);
    else n_pass++;
    wait_cs(1'b1, 200, ok);
    m_ready = 1'b1;  // DONE cycle: pop and write coincide
    @(posedge clk);
    #1 m_ready = 1'b0;
    @(negedge clk);
    n_total++;
    if (!ok || overrun !== 1'b0 || m_valid !== 1'b1)
      $display("FAIL bp_pop_with_write: got ok=%0d ov=%b v=%b exp 1 0 1", ok, overrun, m_valid);
    else n_pass++;
    enable  = 1'b0;
    m_ready = 1'b1;
    wait_pden(1'b1, 200, ok);
    sb.delete();
    obs_q.delete();
  endtask

  task automatic test_fmt_err();
    bit ok;
    int base;
    inject_bad = 1'b1;
    chan_mode  = 2'b00;
    base       = n_writes;
    @(posedge clk);
    #1 enable = 1'b1;
    wait_writes(base + 1, 300, ok);
    enable = 1'b0;
    n_total++;
    if (!ok || fmt_err !== 1'b1) $display("FAIL fmt_err_set: got ok=%0d fe=%b exp 1 1", ok, fmt_err);
    else n_pass++;
    inject_bad = 1'b0;
    @(posedge clk);
    #1 clr_status = 1'b1;
    @(posedge clk);
    #1 clr_status = 1'b0;
    @(negedge clk);
    n_total++;
    if (fmt_err !== 1'b0) $display("FAIL fmt_err_clear: got %b exp 0", fmt_err);
    else n_pass++;
    wait_pden(1'b1, 200, ok);
    sb.delete();
    obs_q.delete();
  endtask

  task automatic test_disable_mid_shift();
    bit ok;
    int base, rise, falls0;
    logic p4, p5;
    chan_mode = 2'b01;
    @(posedge clk);
    #1 enable = 1'b1;
    wait_cs(1'b0, 200, ok);
    n_total++;
    if (!ok || chsel !== 1'b1) $display("FAIL ch1_mode: got ok=%0d chsel=%b exp 1 1", ok, chsel);
    else n_pass++;
    for (int i = 0; i < 200 && fall_cnt < 8; i++) @(negedge clk);
    enable = 1'b0;
    base   = n_writes;
    wait_cs(1'b1, 200, ok);
    rise = cyc;
    while (cyc < rise + 4) @(negedge clk);
    p4 = pden;
    @(negedge clk);
    p5 = pden;
    n_total++;
    if ({p4, p5} !== 2'b01) $display("FAIL dis_pden_time: got %b%b exp 01", p4, p5);
    else n_pass++;
    n_total++;
    if (n_writes != base + 1) $display("FAIL dis_delivered: got %0d writes exp 1", n_writes - base);
    else n_pass++;
    falls0 = cs_falls;
    repeat (150) @(negedge clk);
    n_total++;
    if (cs_falls != falls0 || pden !== 1'b1)
      $display("FAIL dis_stays_off: got %0d falls pden=%b exp 0 1", cs_falls - falls0, pden);
    else n_pass++;
    sb.delete();
    obs_q.delete();
  endtask

  task automatic test_async_reset();
    bit ok;
    chan_mode = 2'b10;
    @(posedge clk);
    #1 enable = 1'b1;
    wait_cs(1'b0, 200, ok);
    wait_cs(1'b1, 200, ok);
    wait_cs(1'b0, 200, ok);
    n_total++;
    if (!ok || chsel !== 1'b1) $display("FAIL ar_pre_chsel: got ok=%0d chsel=%b exp 1 1", ok, chsel);
    else n_pass++;
    for (int i = 0; i < 200 && fall_cnt < 11; i++) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({cs_n, sclk, pden, m_valid} !== 4'b1110)
      $display("FAIL ar_immediate: got cs_n=%b sclk=%b pden=%b v=%b exp 1 1 1 0", cs_n, sclk, pden, m_valid);
    else n_pass++;
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_cs(1'b0, 200, ok);
    n_total++;
    if (!ok || chsel !== 1'b0) $display("FAIL ar_restart0: got ok=%0d chsel=%b exp 1 0", ok, chsel);
    else n_pass++;
    wait_cs(1'b1, 200, ok);
    wait_cs(1'b0, 200, ok);
    n_total++;
    if (!ok || chsel !== 1'b1) $display("FAIL ar_restart1: got ok=%0d chsel=%b exp 1 1", ok, chsel);
    else n_pass++;
    enable = 1'b0;
    wait_pden(1'b1, 200, ok);
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_backpressure();
    test_fmt_err();
    test_disable_mid_shift();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: got no finish exp finish before 1ms");
    $fatal(1, "timeout");
  end

endmodule
